// File: rtl/seq_arith_pkg.sv
// Shared opcode encodings and state/operation enums for the sequential arithmetic unit.
package seq_arith_pkg;

   localparam logic [7:0] OP_ADD = 8'h02;
   localparam logic [7:0] OP_SUB = 8'h03;
   localparam logic [7:0] OP_MUL = 8'h04;
   localparam logic [7:0] OP_DIV = 8'h05;
   localparam logic [7:0] OP_MOD = 8'h06;
   localparam logic [7:0] OP_INC = 8'h07;
   localparam logic [7:0] OP_DEC = 8'h08;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_e;

   typedef enum logic [1:0] {
      IT_MUL,
      IT_DIV,
      IT_MOD
   } iter_e;

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative one-bit-per-cycle engine: shift-add multiply and restoring divide.
// hi/lo hold {product high, multiplier/product low} or {remainder, quotient}.
module seq_muldiv_core #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             div_mode_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] b_q;
   logic [CW-1:0]    cnt_q;
   logic             busy_q;
   logic             div_q;
   logic [WIDTH:0]   msum;
   logic [WIDTH:0]   rsh;
   logic             rsh_ge_b;
   logic [WIDTH-1:0] rem_sub;

   always_comb begin
      msum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      rsh      = {hi_q, lo_q[WIDTH-1]};
      rsh_ge_b = (rsh >= {1'b0, b_q});
      // The shifted remainder is below 2*b, so the difference always fits in WIDTH bits.
      rem_sub  = rsh[WIDTH-1:0] - b_q;
      hi_d     = msum[WIDTH:1];
      lo_d     = {msum[0], lo_q[WIDTH-1:1]};
      if (div_q) begin
         if (rsh_ge_b) begin
            hi_d = rem_sub;
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            hi_d = rsh[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q   <= '0;
         lo_q   <= '0;
         b_q    <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         div_q  <= 1'b0;
      end else if (start_i && !busy_q) begin
         hi_q   <= '0;
         lo_q   <= a_i;
         b_q    <= b_i;
         cnt_q  <= CW'(WIDTH - 1);
         busy_q <= 1'b1;
         div_q  <= div_mode_i;
      end else if (busy_q) begin
         hi_q <= hi_d;
         lo_q <= lo_d;
         if (cnt_q == '0) begin
            busy_q <= 1'b0;
         end else begin
            cnt_q <= cnt_q - CW'(1);
         end
      end
   end

   assign busy_o = busy_q;
   assign done_o = busy_q && (cnt_q == '0);
   assign hi_o   = hi_d;
   assign lo_o   = lo_d;

endmodule

// File: rtl/seq_arith_unit.sv
// Handshaked arithmetic unit: single-cycle ADD/SUB/INC/DEC on a shared adder,
// iterative MUL/DIV/MOD through seq_muldiv_core, one operation in flight.
module seq_arith_unit
   import seq_arith_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int OPW   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [OPW-1:0]     opcode,
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result,
   output logic               carry,
   output logic               err
);

   localparam logic [OPW-1:0] C_ADD = OPW'(OP_ADD);
   localparam logic [OPW-1:0] C_SUB = OPW'(OP_SUB);
   localparam logic [OPW-1:0] C_MUL = OPW'(OP_MUL);
   localparam logic [OPW-1:0] C_DIV = OPW'(OP_DIV);
   localparam logic [OPW-1:0] C_MOD = OPW'(OP_MOD);
   localparam logic [OPW-1:0] C_INC = OPW'(OP_INC);
   localparam logic [OPW-1:0] C_DEC = OPW'(OP_DEC);

   state_e             state_q;
   iter_e              iter_q, iter_d;
   logic               in_ready_q;
   logic               out_valid_q;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic               carry_q, carry_d;
   logic               err_q, err_d;

   logic               is_mul, is_div, is_mod, is_addc;
   logic               add_inv, add_cin, use_b;
   logic [WIDTH-1:0]   add_b;
   logic [WIDTH-1:0]   add_sum;
   logic               add_cout;
   logic               iter_start;
   logic               core_busy, core_done;
   logic [WIDTH-1:0]   core_hi, core_lo;

   always_comb begin
      is_mul  = (opcode == C_MUL);
      is_div  = (opcode == C_DIV);
      is_mod  = (opcode == C_MOD);
      is_addc = (opcode == C_ADD) || (opcode == C_SUB) ||
                (opcode == C_INC) || (opcode == C_DEC);

      // SUB = a+~b+1, INC = a+0+1, DEC = a+~0+0 (i.e. a + all-ones).
      use_b   = (opcode == C_ADD) || (opcode == C_SUB);
      add_inv = (opcode == C_SUB) || (opcode == C_DEC);
      add_cin = (opcode == C_SUB) || (opcode == C_INC);
      add_b   = use_b ? op_b : '0;
      if (add_inv) begin
         add_b = ~add_b;
      end
      {add_cout, add_sum} = {1'b0, op_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

      iter_start = (state_q == IDLE) && in_valid && !core_busy &&
                   (is_mul || ((is_div || is_mod) && (op_b != '0)));
      iter_d     = is_mul ? IT_MUL : (is_div ? IT_DIV : IT_MOD);

      result_d = '0;
      carry_d  = 1'b0;
      err_d    = 1'b0;
      if (state_q == CALC) begin
         case (iter_q)
            IT_MUL:  result_d = {core_hi, core_lo};
            IT_DIV:  result_d = {{WIDTH{1'b0}}, core_lo};
            default: result_d = {{WIDTH{1'b0}}, core_hi};
         endcase
      end else if (is_addc) begin
         result_d = {{WIDTH{1'b0}}, add_sum};
         carry_d  = add_cout;
      end else begin
         err_d = 1'b1;
      end
   end

   seq_muldiv_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .clk       (clk),
      .rst       (rst),
      .start_i   (iter_start),
      .div_mode_i(!is_mul),
      .a_i       (op_a),
      .b_i       (op_b),
      .busy_o    (core_busy),
      .done_o    (core_done),
      .hi_o      (core_hi),
      .lo_o      (core_lo)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         iter_q      <= IT_MUL;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         carry_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  in_ready_q <= 1'b0;
                  if (iter_start) begin
                     state_q <= CALC;
                     iter_q  <= iter_d;
                  end else begin
                     state_q     <= DONE;
                     out_valid_q <= 1'b1;
                     result_q    <= result_d;
                     carry_q     <= carry_d;
                     err_q       <= err_d;
                  end
               end
            end
            CALC: begin
               if (core_done) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
                  result_q    <= result_d;
                  carry_q     <= carry_d;
                  err_q       <= err_d;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign carry     = carry_q;
   assign err       = err_q;

endmodule
